// File: rtl/axi2ahb_rd_buf_mo.sv
// Read-data return buffer for the AXI-to-AHB bridge: captures AHB read beats, tags them with
// ID/RRESP/RLAST from a queue of admitted bursts, and presents them show-ahead on the AXI R channel.
module axi2ahb_rd_buf_mo #(
    parameter int         DATA_BITS   = 32,
    parameter int         ID_BITS     = 4,
    parameter int         FIFO_LINES  = 32,
    parameter int         MAX_BEATS   = 16,
    parameter int         MAX_BURSTS  = 2,
    parameter bit         STICKY_ERR  = 1'b1,
    parameter logic [1:0] RESP_SLVERR = 2'b10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_start,
    input  logic [ID_BITS-1:0]           cmd_id,
    input  logic [3:0]                   cmd_len,
    input  logic                         cmd_err,
    output logic                         rdata_ready,
    input  logic                         rdata_phase,
    input  logic [DATA_BITS-1:0]         HRDATA,
    input  logic                         HREADY,
    input  logic                         HRESP,
    output logic [ID_BITS-1:0]           RID,
    output logic [DATA_BITS-1:0]         RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RLAST,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [$clog2(FIFO_LINES):0]  fifo_level,
    output logic                         proto_err
);

    localparam int AW = $clog2(FIFO_LINES);
    localparam int LW = AW + 1;
    localparam int CW = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS) : 1;
    localparam int BW = $clog2(MAX_BURSTS) + 1;

    logic          init_q, init_d;
    logic [LW-1:0] cnt_q, cnt_d, res_q, res_d;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [BW-1:0] bcnt_q, bcnt_d, cq_cnt_q, cq_cnt_d;
    logic [CW-1:0] cq_wp_q, cq_wp_d, cq_rp_q, cq_rp_d;
    logic [3:0]    beat_q, beat_d;
    logic          sticky_q, sticky_d;
    logic          perr_q, perr_d;

    logic [ID_BITS-1:0]   cq_id   [MAX_BURSTS];
    logic [3:0]           cq_len  [MAX_BURSTS];
    logic                 cq_err  [MAX_BURSTS];
    logic [DATA_BITS-1:0] mem_data[FIFO_LINES];
    logic [ID_BITS-1:0]   mem_id  [FIFO_LINES];
    logic [1:0]           mem_resp[FIFO_LINES];
    logic                 mem_last[FIFO_LINES];

    logic          acc, push, push_ok, drop, pop, last_pop, full, cq_empty, beat_last, cq_pop;
    logic [LW-1:0] free;
    logic [1:0]    beat_resp;

    function automatic logic [CW-1:0] cq_inc(input logic [CW-1:0] p);
        return (p == CW'(MAX_BURSTS - 1)) ? '0 : p + CW'(1);
    endfunction

    assign RVALID      = (cnt_q != '0);
    assign pop         = RVALID & RREADY;
    assign last_pop    = pop & mem_last[rp_q];
    assign free        = LW'(FIFO_LINES) - res_q;
    // Admission needs room for a worst-case burst, so an admitted burst can never overflow.
    assign rdata_ready = init_q & (bcnt_q < BW'(MAX_BURSTS)) & (free >= LW'(MAX_BEATS));
    assign acc         = cmd_start & rdata_ready;

    assign push      = rdata_phase & HREADY;
    assign cq_empty  = (cq_cnt_q == '0);
    assign full      = (cnt_q == LW'(FIFO_LINES));
    assign push_ok   = push & ~cq_empty & (~full | pop);
    assign drop      = push & ~push_ok;
    assign beat_last = (beat_q == cq_len[cq_rp_q]);
    assign cq_pop    = push_ok & beat_last;
    assign beat_resp = (cq_err[cq_rp_q] | HRESP | (STICKY_ERR & sticky_q)) ? RESP_SLVERR : 2'b00;

    always_comb begin
        init_d   = 1'b1;
        cnt_d    = cnt_q;
        res_d    = res_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        bcnt_d   = bcnt_q;
        cq_cnt_d = cq_cnt_q;
        cq_wp_d  = cq_wp_q;
        cq_rp_d  = cq_rp_q;
        beat_d   = beat_q;
        sticky_d = sticky_q;
        perr_d   = perr_q | drop;

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push_ok) wp_d = wp_q + AW'(1);
        if (pop)     rp_d = rp_q + AW'(1);

        res_d = res_q + (acc ? (LW'(cmd_len) + LW'(1)) : '0) - (pop ? LW'(1) : '0);

        case ({acc, last_pop})
            2'b10:   bcnt_d = bcnt_q + BW'(1);
            2'b01:   bcnt_d = bcnt_q - BW'(1);
            default: bcnt_d = bcnt_q;
        endcase

        if (acc)    cq_wp_d = cq_inc(cq_wp_q);
        if (cq_pop) cq_rp_d = cq_inc(cq_rp_q);
        case ({acc, cq_pop})
            2'b10:   cq_cnt_d = cq_cnt_q + BW'(1);
            2'b01:   cq_cnt_d = cq_cnt_q - BW'(1);
            default: cq_cnt_d = cq_cnt_q;
        endcase

        if (push_ok) begin
            beat_d   = beat_last ? 4'd0 : beat_q + 4'd1;
            sticky_d = beat_last ? 1'b0 : (sticky_q | HRESP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_q   <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            bcnt_q   <= '0;
            cq_cnt_q <= '0;
            cq_wp_q  <= '0;
            cq_rp_q  <= '0;
            beat_q   <= '0;
            sticky_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            init_q   <= init_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            bcnt_q   <= bcnt_d;
            cq_cnt_q <= cq_cnt_d;
            cq_wp_q  <= cq_wp_d;
            cq_rp_q  <= cq_rp_d;
            beat_q   <= beat_d;
            sticky_q <= sticky_d;
            perr_q   <= perr_d;
        end
    end

    // Storage arrays carry no reset; their contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (acc) begin
            cq_id[cq_wp_q]  <= cmd_id;
            cq_len[cq_wp_q] <= cmd_len;
            cq_err[cq_wp_q] <= cmd_err;
        end
        if (push_ok) begin
            mem_data[wp_q] <= HRDATA;
            mem_id[wp_q]   <= cq_id[cq_rp_q];
            mem_resp[wp_q] <= beat_resp;
            mem_last[wp_q] <= beat_last;
        end
    end

    assign RID        = RVALID ? mem_id[rp_q]   : '0;
    assign RDATA      = RVALID ? mem_data[rp_q] : '0;
    assign RRESP      = RVALID ? mem_resp[rp_q] : 2'b00;
    assign RLAST      = RVALID ? mem_last[rp_q] : 1'b0;
    assign fifo_level = cnt_q;
    assign proto_err  = perr_q;

endmodule

// File: tb/tb_axi2ahb_rd_buf_mo.sv
// Bench for axi2ahb_rd_buf_mo: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_axi2ahb_rd_buf_mo;

    localparam int FL = 32;
    localparam int MAXBE = 16;
    localparam int MAXB = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic [3:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic        cmd_err;
    logic        rdata_ready;
    logic        rdata_phase;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [5:0]  fifo_level;
    logic        proto_err;

    axi2ahb_rd_buf_mo dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .cmd_err(cmd_err), .rdata_ready(rdata_ready), .rdata_phase(rdata_phase), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY), .fifo_level(fifo_level), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] id; logic [3:0] len; logic err; } cmd_t;
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } beat_t;

    int tests = 0;
    int fails = 0;

    cmd_t  mcq[$];
    beat_t mdq[$];
    beat_t plog[$];
    int    m_res, m_bcnt, m_beat;
    bit    m_sticky, m_perr, m_started;
    bit    m_rdy, m_pop, m_new;
    beat_t nb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bursts and beats as queues, updated on each active edge
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mcq.delete(); mdq.delete();
            m_res = 0; m_bcnt = 0; m_beat = 0;
            m_sticky = 0; m_perr = 0; m_started = 0;
        end else begin
            m_rdy = m_started && (m_bcnt < MAXB) && ((FL - m_res) >= MAXBE);
            m_pop = (mdq.size() != 0) && RREADY;
            m_new = 0;
            if (rdata_phase && HREADY) begin
                if (mcq.size() == 0 || (mdq.size() == FL && !m_pop)) begin
                    m_perr = 1;
                end else begin
                    nb.id   = mcq[0].id;
                    nb.data = HRDATA;
                    nb.last = (m_beat == int'(mcq[0].len));
                    nb.resp = (mcq[0].err || HRESP || m_sticky) ? 2'b10 : 2'b00;
                    m_sticky = nb.last ? 1'b0 : (m_sticky | HRESP);
                    m_beat   = nb.last ? 0 : m_beat + 1;
                    if (nb.last) void'(mcq.pop_front());
                    m_new = 1;
                end
            end
            if (m_pop) begin
                if (mdq[0].last) m_bcnt--;
                void'(mdq.pop_front());
                m_res--;
            end
            if (m_new) mdq.push_back(nb);
            if (cmd_start && m_rdy) begin
                mcq.push_back('{cmd_id, cmd_len, cmd_err});
                m_res += int'(cmd_len) + 1;
                m_bcnt++;
            end
            m_started = 1;
        end
    end

    // Compare DUT against the model on every falling edge; also log each R handshake
    initial forever begin
        @(negedge clk);
        chk("rvalid", RVALID, mdq.size() != 0);
        chk("rdata_ready", rdata_ready, m_started && (m_bcnt < MAXB) && ((FL - m_res) >= MAXBE));
        chk("fifo_level", fifo_level, mdq.size());
        chk("proto_err", proto_err, m_perr);
        if (mdq.size() != 0) begin
            chk("rid", RID, mdq[0].id);
            chk("rdata", RDATA, mdq[0].data);
            chk("rresp", RRESP, mdq[0].resp);
            chk("rlast", RLAST, mdq[0].last);
        end
        if (reset && RVALID && RREADY) plog.push_back('{RID, RDATA, RRESP, RLAST});
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic burst(input logic [3:0] id, input logic [3:0] len, input logic err,
                         input int hresp_beat, input logic [31:0] base);
        cmd_start = 1; cmd_id = id; cmd_len = len; cmd_err = err;
        step();
        cmd_start = 0;
        for (int i = 0; i <= int'(len); i++) begin
            rdata_phase = 1; HREADY = 1; HRESP = (i == hresp_beat); HRDATA = base + i;
            step();
        end
        rdata_phase = 0; HRESP = 0;
    endtask

    initial begin
        reset = 0; cmd_start = 0; cmd_id = 0; cmd_len = 0; cmd_err = 0;
        rdata_phase = 0; HRDATA = 0; HREADY = 0; HRESP = 0; RREADY = 0;
        #3;
        chk("reset_rvalid", RVALID, 0);
        chk("reset_rlast", RLAST, 0);
        chk("reset_rresp", RRESP, 0);
        chk("reset_rid", RID, 0);
        chk("reset_rdata", RDATA, 0);
        chk("reset_perr", proto_err, 0);
        chk("reset_level", fifo_level, 0);
        repeat (3) step();
        reset = 1;
        chk("ready_before_first_edge", rdata_ready, 0);
        step();
        chk("ready_after_release", rdata_ready, 1);

        // Single burst id=3 len=3
        RREADY = 1; plog.delete();
        cmd_start = 1; cmd_id = 3; cmd_len = 3; cmd_err = 0;
        step();
        cmd_start = 0;
        chk("single_rvalid_pre", RVALID, 0);
        for (int i = 0; i < 4; i++) begin
            rdata_phase = 1; HREADY = 1; HRDATA = 32'hA000_0000 + i;
            step();
            if (i == 0) begin
                chk("single_rvalid_lat1", RVALID, 1);
                chk("single_first_data", RDATA, 32'hA000_0000);
            end
        end
        rdata_phase = 0;
        repeat (4) step();
        chk("single_count", plog.size(), 4);
        for (int i = 0; i < plog.size() && i < 4; i++) begin
            chk("single_id", plog[i].id, 3);
            chk("single_data", plog[i].data, 32'hA000_0000 + i);
            chk("single_resp", plog[i].resp, 0);
            chk("single_last", plog[i].last, i == 3);
        end

        // Error handling: sticky HRESP, clean follow-up, pre-errored burst
        plog.delete();
        burst(4, 3, 0, 1, 32'hB000_0000);
        burst(4, 3, 0, -1, 32'hB100_0000);
        burst(9, 1, 1, -1, 32'hB200_0000);
        repeat (5) step();
        chk("err_count", plog.size(), 10);
        if (plog.size() == 10) begin
            chk("err_b0", plog[0].resp, 2'b00);
            chk("err_b1", plog[1].resp, 2'b10);
            chk("err_b2", plog[2].resp, 2'b10);
            chk("err_b3", plog[3].resp, 2'b10);
            for (int i = 4; i < 8; i++) chk("clean_resp", plog[i].resp, 2'b00);
            chk("cmderr_b0", plog[8].resp, 2'b10);
            chk("cmderr_b1", plog[9].resp, 2'b10);
            chk("cmderr_id", plog[9].id, 9);
            chk("cmderr_last", plog[9].last, 1);
        end

        // Simultaneous push/pop keeps level constant
        cmd_start = 1; cmd_id = 6; cmd_len = 7; cmd_err = 0;
        step();
        cmd_start = 0;
        for (int i = 0; i < 8; i++) begin
            rdata_phase = 1; HREADY = 1; HRDATA = 32'hC000_0000 + i;
            step();
            chk("pushpop_level", fifo_level, 1);
        end
        rdata_phase = 0;
        repeat (3) step();

        // Two outstanding maximum bursts with back-pressure
        RREADY = 0;
        cmd_start = 1; cmd_id = 1; cmd_len = 15;
        step();
        chk("ready_after_1st", rdata_ready, 1);
        cmd_id = 2;
        step();
        chk("ready_after_2nd", rdata_ready, 0);
        cmd_start = 0;
        for (int i = 0; i < 32; i++) begin
            rdata_phase = 1; HREADY = 1; HRDATA = 32'hD000_0000 + i;
            step();
        end
        chk("full_level", fifo_level, 32);
        chk("full_perr_before", proto_err, 0);
        HRDATA = 32'hDEAD_BEEF;
        step();
        rdata_phase = 0;
        chk("full_perr_after", proto_err, 1);
        chk("full_level_held", fifo_level, 32);
        plog.delete();
        RREADY = 1;
        begin
            int n = 0;
            while (!rdata_ready && n < 40) begin step(); n++; end
        end
        chk("ready_rises", rdata_ready, 1);
        chk("level_at_ready", fifo_level, 16);
        repeat (20) step();
        chk("two_count", plog.size(), 32);
        if (plog.size() == 32) begin
            chk("two_last14", plog[14].last, 0);
            chk("two_last15", plog[15].last, 1);
            chk("two_id16", plog[16].id, 2);
            chk("two_data31", plog[31].data, 32'hD000_001F);
            chk("two_last31", plog[31].last, 1);
        end

        // Reset mid-burst
        RREADY = 0;
        cmd_start = 1; cmd_id = 7; cmd_len = 7;
        step();
        cmd_start = 0;
        for (int i = 0; i < 2; i++) begin
            rdata_phase = 1; HREADY = 1; HRDATA = 32'hE000_0000 + i;
            step();
        end
        rdata_phase = 0;
        reset = 0;
        #1;
        chk("midrst_rvalid", RVALID, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_perr", proto_err, 0);
        repeat (2) step();
        reset = 1;
        step();
        plog.delete();
        RREADY = 1;
        burst(5, 3, 0, -1, 32'hF000_0000);
        repeat (5) step();
        chk("postrst_count", plog.size(), 4);
        for (int i = 0; i < plog.size() && i < 4; i++) begin
            chk("postrst_id", plog[i].id, 5);
            chk("postrst_data", plog[i].data, 32'hF000_0000 + i);
            chk("postrst_last", plog[i].last, i == 3);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            RREADY      = ($urandom % 4) != 0;
            cmd_start   = ($urandom % 3) == 0;
            cmd_id      = 4'($urandom);
            cmd_len     = 4'($urandom);
            cmd_err     = ($urandom % 8) == 0;
            rdata_phase = ((mcq.size() != 0) && ($urandom % 4 != 0)) || ($urandom % 200 == 0);
            HREADY      = ($urandom % 4) != 0;
            HRESP       = ($urandom % 10) == 0;
            HRDATA      = $urandom;
            step();
        end
        cmd_start = 0; rdata_phase = 0; HRESP = 0; RREADY = 1;
        repeat (40) step();
        chk("drain_empty", RVALID, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
